// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Optional fetch reuse is enabled by defining INSTR_FETCH_REUSE_EN.
package instr_fetch_ctrl_pkg;

   localparam int XLEN  = 16;
   localparam int CNT_W = 8;

   localparam logic [XLEN-1:0] INSTR_NOP = 16'h0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ctrl_timeout_counter.sv
// Wait counter for an outstanding memory request.
// Terminal count is asserted while the count equals TIMEOUT.
module fetch_timeout_counter
   import instr_fetch_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic clr_n,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory read per PC request.
// Define INSTR_FETCH_REUSE_EN to serve repeat addresses without memory.
module instr_fetch_ctrl
   import instr_fetch_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            clr_n,
   input  logic [XLEN-1:0] pc_addr,
   input  logic            pc_valid,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   output logic            stall,
   output logic            fetch_fault,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata
);

   fetch_state_t    state_q;
   fetch_state_t    state_d;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] addr_d;
   logic [XLEN-1:0] instr_q;
   logic [XLEN-1:0] instr_d;
   logic            discard_q;
   logic            discard_d;
   logic            valid_q;
   logic            fault_q;
   logic            fault_d;
   logic            req_q;
   logic            ready_q;
   logic            capture;
   logic            redirect;
   logic            reuse_hit;
   logic            cnt_clear;
   logic            cnt_en;
   logic            tc;

   fetch_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_cnt (
      .clk    (clk),
      .clr_n  (clr_n),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .tc     (tc)
   );

   assign redirect = !pc_valid || (pc_addr != addr_q);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      instr_d   = instr_q;
      discard_d = discard_q;
      fault_d   = 1'b0;
      capture   = 1'b0;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pc_valid && ready_q) begin
               if (reuse_hit) begin
                  state_d = S_DONE;
               end else begin
                  state_d   = S_REQ;
                  addr_d    = pc_addr;
                  cnt_clear = 1'b1;
               end
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               discard_d = 1'b0;
               // A redirect seen in the ack cycle itself also stales the data
               if (discard_q || redirect) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
                  instr_d = mem_rdata;
                  capture = 1'b1;
               end
            end else if (tc) begin
               state_d   = S_IDLE;
               fault_d   = 1'b1;
               discard_d = 1'b0;
            end else begin
               cnt_en = 1'b1;
               if (redirect) begin
                  discard_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         instr_q   <= INSTR_NOP;
         discard_q <= 1'b0;
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
         req_q     <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         instr_q   <= instr_d;
         discard_q <= discard_d;
         valid_q   <= (state_d == S_DONE);
         fault_q   <= fault_d;
         req_q     <= (state_d == S_REQ);
         ready_q   <= 1'b1;
      end
   end

`ifdef INSTR_FETCH_REUSE_EN
   logic            reuse_q;
   logic [XLEN-1:0] last_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         reuse_q <= 1'b0;
         last_q  <= '0;
      end else if (fault_d) begin
         reuse_q <= 1'b0;
      end else if (capture) begin
         reuse_q <= 1'b1;
         last_q  <= addr_q;
      end
   end

   assign reuse_hit = reuse_q && (pc_addr == last_q);
`else
   assign reuse_hit = 1'b0;
`endif

   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign fetch_fault = fault_q;
   assign mem_req     = req_q;
   assign mem_addr    = addr_q;
   assign stall       = pc_valid && !valid_q;

endmodule
